mux_channel_scanner: RTL and testbench



---
 rtl/mux_channel_scanner_if.sv | 28 ++
 rtl/mux_channel_scanner.sv | 138 +++++++++++++
 tb/tb_mux_channel_scanner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_channel_scanner_if.sv
// Control and status bundle between the channel scanner, its controller and the 4:1 mux.
// The slave side is the scanner; the master side is whatever drives start/mask and the mux output.
interface mux_channel_scanner_if;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [3:0] ch_mask;
  logic       y_in;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic       sample_bit;
  logic [3:0] frame_data;
  logic       frame_done;
  logic       err;

  modport master (
    output start, stop, continuous, ch_mask, y_in,
    input  s0, s1, busy, sample_valid, sample_ch, sample_bit, frame_data, frame_done, err
  );

  modport slave (
    input  start, stop, continuous, ch_mask, y_in,
    output s0, s1, busy, sample_valid, sample_ch, sample_bit, frame_data, frame_done, err
  );
endinterface

// File: rtl/mux_channel_scanner.sv
// Steps the 4:1 mux select through the enabled channels, settles, samples y, and
// publishes one 4-bit snapshot per completed frame.
module mux_channel_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_channel_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t           state_reg;
  logic [1:0]       ch_reg;
  logic [3:0]       mask_reg;
  logic [3:0]       shadow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             sample_valid_reg;
  logic [1:0]       sample_ch_reg;
  logic             sample_bit_reg;
  logic [3:0]       frame_data_reg;
  logic             frame_done_reg;
  logic             err_reg;

  logic [3:0]       shadow_cap;
  logic [3:0]       higher_mask;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Shadow as it will be after the current SAMPLE edge captures y into its slot.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign shadow_cap[gi] = (ch_reg == 2'(gi)) ? bus.y_in : shadow_reg[gi];
  end

  // Enabled channels strictly above the current one (empty when ch_reg == 3).
  assign higher_mask = mask_reg & ~((4'd2 << ch_reg) - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      ch_reg           <= 2'd0;
      mask_reg         <= 4'd0;
      shadow_reg       <= 4'd0;
      cnt_reg          <= '0;
      busy_reg         <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_ch_reg    <= 2'd0;
      sample_bit_reg   <= 1'b0;
      frame_data_reg   <= 4'd0;
      frame_done_reg   <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      err_reg          <= 1'b0;
      if (state_reg != IDLE && bus.stop) begin
        // Abort drops any partial frame, including a sample in flight.
        state_reg <= IDLE;
        ch_reg    <= 2'd0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              if (bus.ch_mask != 4'd0) begin
                mask_reg   <= bus.ch_mask;
                shadow_reg <= 4'd0;
                ch_reg     <= lowest_ch(bus.ch_mask);
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
                state_reg  <= SETTLE;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
              state_reg <= SAMPLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          SAMPLE: begin
            shadow_reg       <= shadow_cap;
            sample_valid_reg <= 1'b1;
            sample_ch_reg    <= ch_reg;
            sample_bit_reg   <= bus.y_in;
            cnt_reg          <= '0;
            if (higher_mask != 4'd0) begin
              ch_reg    <= lowest_ch(higher_mask);
              state_reg <= SETTLE;
            end else begin
              frame_data_reg <= shadow_cap & mask_reg;
              frame_done_reg <= 1'b1;
              if (bus.continuous && bus.ch_mask != 4'd0) begin
                mask_reg   <= bus.ch_mask;
                shadow_reg <= 4'd0;
                ch_reg     <= lowest_ch(bus.ch_mask);
                state_reg  <= SETTLE;
              end else begin
                ch_reg    <= 2'd0;
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
                if (bus.continuous) err_reg <= 1'b1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            ch_reg    <= 2'd0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.s0           = ch_reg[0];
  assign bus.s1           = ch_reg[1];
  assign bus.busy         = busy_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.sample_ch    = sample_ch_reg;
  assign bus.sample_bit   = sample_bit_reg;
  assign bus.frame_data   = frame_data_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.err          = err_reg;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: a behavioural 4:1 mux feeds y_in, and expected
// schedules are derived from the per-channel cost of SETTLE+1 cycles.
module tb_mux_channel_scanner;
  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mux_data;
  logic [3:0] last_frame;
  logic [3:0] d;
  int         compared   = 0;
  int         mismatched = 0;

  mux_channel_scanner_if bus();

  mux_channel_scanner #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The mux itself: y follows whichever channel the scanner selects.
  assign bus.y_in = mux_data[{bus.s1, bus.s0}];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input int c, input logic [1:0] sel,
                         input logic busy, input logic fd);
    chk($sformatf("%s sel c%0d", tag, c), 8'({bus.s1, bus.s0}), 8'(sel));
    chk($sformatf("%s busy c%0d", tag, c), 8'(bus.busy), 8'(busy));
    chk($sformatf("%s frame_done c%0d", tag, c), 8'(bus.frame_done), 8'(fd));
  endtask

  task automatic run_oneshot(input logic [3:0] m, input logic [3:0] dd, input bit disturb);
    int e[4];
    int n;
    int j;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      e[i] = 0;
      if (m[i]) begin
        e[n] = i;
        n++;
      end
    end
    mux_data        = dd;
    bus.ch_mask     = m;
    bus.continuous  = 1'b0;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= n * P + 1; c++) begin
      j = (c - 1) / P;
      if (c <= n * P) begin
        chk_cyc("oneshot", c, 2'(e[j]), 1'b1, 1'b0);
      end else begin
        chk_cyc("oneshot", c, 2'd0, 1'b0, 1'b1);
        chk($sformatf("oneshot frame_data m=%b", m), 8'(bus.frame_data), 8'(dd & m));
      end
      if (c > 1 && (c - 1) % P == 0) begin
        chk($sformatf("oneshot sample_valid c%0d", c), 8'(bus.sample_valid), 8'd1);
        chk($sformatf("oneshot sample_ch c%0d", c), 8'(bus.sample_ch), 8'(e[j - 1]));
        chk($sformatf("oneshot sample_bit c%0d", c), 8'(bus.sample_bit), 8'(dd[e[j - 1]]));
      end else begin
        chk($sformatf("oneshot sample_valid c%0d", c), 8'(bus.sample_valid), 8'd0);
      end
      chk($sformatf("oneshot err c%0d", c), 8'(bus.err), 8'd0);
      if (disturb) begin
        bus.start = (c == 2);
        if (c == 2) bus.ch_mask = 4'($urandom);
      end
      step();
    end
    bus.start  = 1'b0;
    last_frame = dd & m;
    $display("oneshot mask=%b data=%b disturb=%0d -> frame_data=%b", m, dd, disturb, bus.frame_data);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    bus.ch_mask    = 4'd0;
    mux_data       = 4'd0;
    last_frame     = 4'd0;
    step();
    step();
    chk_cyc("reset", 0, 2'd0, 1'b0, 1'b0);
    chk("reset frame_data", 8'(bus.frame_data), 8'd0);
    chk("reset sample_valid", 8'(bus.sample_valid), 8'd0);
    chk("reset err", 8'(bus.err), 8'd0);
    rst_n = 1'b1;
    step();

    run_oneshot(4'b1111, 4'b0100, 1'b0);
    run_oneshot(4'b1010, 4'b1111, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_oneshot(m, 4'($urandom), k[0]);
    end

    // Continuous with a mid-frame mask change that only lands at the next wrap.
    d              = 4'($urandom);
    mux_data       = d;
    bus.ch_mask    = 4'b0001;
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      logic [1:0] es;
      logic       efd;
      es  = (c <= 6) ? 2'd0 : ((c == 13) ? 2'd0 : 2'd3);
      efd = (c > 1) && (c % 3 == 1);
      chk_cyc("cont", c, es, 1'(c <= 12), efd);
      if (efd) chk($sformatf("cont frame_data c%0d", c), 8'(bus.frame_data), 8'((c <= 7) ? (d & 4'b0001) : (d & 4'b1000)));
      if (c == 5) bus.ch_mask = 4'b1000;
      if (c == 10) bus.continuous = 1'b0;
      step();
    end
    last_frame = d & 4'b1000;
    $display("continuous data=%b -> frame_data=%b", d, bus.frame_data);

    // Mask emptied before a wrap: frame still publishes, then err and IDLE.
    d              = 4'($urandom);
    mux_data       = d;
    bus.ch_mask    = 4'b0010;
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c <= 3) chk_cyc("wrap0", c, 2'd1, 1'b1, 1'b0);
      else        chk_cyc("wrap0", c, 2'd0, 1'b0, 1'b1);
      chk($sformatf("wrap0 err c%0d", c), 8'(bus.err), 8'(c == 4));
      if (c == 4) chk("wrap0 frame_data", 8'(bus.frame_data), 8'(d & 4'b0010));
      if (c == 2) bus.ch_mask = 4'b0000;
      step();
    end
    bus.continuous = 1'b0;
    last_frame     = d & 4'b0010;
    $display("wrap with empty mask data=%b -> frame_data=%b err pulsed", d, bus.frame_data);

    // Stop during the channel-2 settle.
    mux_data    = 4'($urandom);
    bus.ch_mask = 4'b1111;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk_cyc("stop", c, 2'((c - 1) / P), 1'b1, 1'b0);
      if (c == 7) bus.stop = 1'b1;
      step();
    end
    bus.stop = 1'b0;
    chk_cyc("stop", 8, 2'd0, 1'b0, 1'b0);
    chk("stop frame_data held", 8'(bus.frame_data), 8'(last_frame));
    step();
    chk_cyc("stop", 9, 2'd0, 1'b0, 1'b0);
    chk("stop frame_data held c9", 8'(bus.frame_data), 8'(last_frame));
    $display("stop in ch2 settle -> idle, frame_data=%b kept", bus.frame_data);

    // Empty mask on start, then start+stop together in IDLE.
    bus.ch_mask = 4'b0000;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("err pulse", 8'(bus.err), 8'd1);
    chk("err busy", 8'(bus.busy), 8'd0);
    step();
    chk("err cleared", 8'(bus.err), 8'd0);
    bus.ch_mask = 4'b1111;
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("start+stop busy", 8'(bus.busy), 8'd0);
    chk("start+stop err", 8'(bus.err), 8'd0);
    step();
    chk("start+stop busy later", 8'(bus.busy), 8'd0);
    $display("err on empty mask, start+stop ignored");

    // Asynchronous reset in the middle of the channel-0 SAMPLE.
    run_oneshot(4'b1111, 4'b1111, 1'b0);
    bus.ch_mask = 4'b1111;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async sel", 8'({bus.s1, bus.s0}), 8'd0);
    chk("async busy", 8'(bus.busy), 8'd0);
    chk("async sample_valid", 8'(bus.sample_valid), 8'd0);
    chk("async sample_ch", 8'(bus.sample_ch), 8'd0);
    chk("async sample_bit", 8'(bus.sample_bit), 8'd0);
    chk("async frame_data", 8'(bus.frame_data), 8'd0);
    chk("async frame_done", 8'(bus.frame_done), 8'd0);
    chk("async err", 8'(bus.err), 8'd0);
    #2;
    rst_n = 1'b1;
    step();
    $display("async reset mid-sample -> outputs cleared");
    run_oneshot(4'b1111, 4'b0100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
